// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands four bits per clock through an external
//   combinational 4-bit lookahead carry adder that has no carry-in. The
//   carry between nibbles is folded back in here, and the full-width
//   result is assembled nibble by nibble.
//
// Parameters
//   WIDTH            operand/result width (multiple of 4, at least 4)
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   i_in_valid       operand pair valid
//   o_in_ready       block can accept operands (IDLE)
//   i_in_a, i_in_b   operands
//   o_add_a/o_add_b  nibble driven to the external adder (0 outside RUN)
//   i_add_sum        adder Sum, combinational from o_add_a/o_add_b
//   i_add_cout       adder C_out
//   o_out_valid      result valid (DONE)
//   i_out_ready      downstream accepts result
//   o_out_sum        (in_a + in_b) mod 2^WIDTH
//   o_out_cout       carry out of bit WIDTH-1
//   o_busy           state is not IDLE
//   o_out_ovf        signed overflow; present only with NSA_OVERFLOW_EN
//
// Build option
//   NSA_OVERFLOW_EN  adds the o_out_ovf port and its overflow register.

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [3:0]       o_add_a,
  output logic [3:0]       o_add_b,
  input  logic [3:0]       i_add_sum,
  input  logic             i_add_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout,
`ifdef NSA_OVERFLOW_EN
  output logic             o_out_ovf,
`endif
  output logic             o_busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [3:0]       w_aNib;
  logic [3:0]       w_bNib;
  logic [3:0]       w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;

  // Nibble selection from the latched operands for the current index.
  always_comb begin
    w_aNib = r_a[4*int'(r_idx) +: 4];
    w_bNib = r_b[4*int'(r_idx) +: 4];
  end

  // Carry fixup: the external adder has no carry-in, so the inter-nibble
  // carry is added afterwards. A second carry can only arise when the
  // adder produced 4'hF and the incoming carry is 1.
  always_comb begin
    w_s = i_add_sum + {3'b000, r_carry};
    w_c = i_add_cout | ((&i_add_sum) & r_carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_add_a     = 4'h0;
    o_add_b     = 4'h0;
    w_accept    = 1'b0;
    w_last      = (r_idx == LAST_IDX);
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        o_add_a = w_aNib;
        o_add_b = w_bNib;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_in_a;
      r_b     <= i_in_b;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[4*int'(r_idx) +: 4] <= w_s;
      r_carry                   <= w_c;
      if (w_last) begin
        r_cout <= w_c;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow is decided on the final nibble, where w_s[3] is the
  // result sign bit and the latched operand MSBs are the operand signs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_s[3] != r_a[WIDTH-1]);
    end
  end

  assign o_out_ovf = r_ovf;
`endif

  assign o_out_sum  = r_sum;
  assign o_out_cout = r_cout;
  assign o_busy     = (r_state != IDLE);

endmodule
